// File: rtl/a2d_spi_serf.sv
// a2d_spi_serf
//   SPI serf that stands in for the board's 8-channel 12-bit A2D converter.
//   A 16-bit command arriving on MOSI selects a channel (bits 13:11); the
//   sample for the channel that was current when SS_n fell is returned on
//   MISO, MSB first, as {4'h0, smpl}. This gives the converter's
//   one-transaction pipeline.
//
// Parameters
//   RST_CHNL      channel selected out of reset
//   MIN_HALF_SCLK minimum SCLK half-period (clk cycles); assertion only
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   SS_n          serf select from monarch, active low
//   SCLK          serial clock from monarch, idles high
//   MOSI          command data, MSB first
//   MISO          response data, MSB first; 0 while SS_n is high
//   chnnl         channel from the last accepted command
//   smpl          sample value for chnnl, supplied externally
//   cmd_vld       one-clk pulse when a full 16-bit command is accepted
//   prot_err      one-clk pulse on a malformed transaction
//
// Build option
//   A2D_SERF_CHK_EN  when defined, reserved command bits must be zero and a
//                    simulation assertion checks the SCLK half-period.
module a2d_spi_serf #(
  parameter logic [2:0] RST_CHNL      = 3'd0,
  parameter int         MIN_HALF_SCLK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic [2:0]  chnnl,
  input  logic [11:0] smpl,
  output logic        cmd_vld,
  output logic        prot_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;

  logic        ss_n_ff1, ss_n_ff2, ss_n_ff3;
  logic        sclk_ff1, sclk_ff2, sclk_ff3;
  logic        mosi_ff1, mosi_ff2, mosi_ff3;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;

  logic [15:0] tx_shft, rx_shft;
  logic [4:0]  bit_cnt;
  logic        extra_rise;
  logic        cmd_ok;
  logic        chnnl_ld;

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_ff1 <= 1'b1;
      ss_n_ff2 <= 1'b1;
      ss_n_ff3 <= 1'b1;
      sclk_ff1 <= 1'b1;
      sclk_ff2 <= 1'b1;
      sclk_ff3 <= 1'b1;
      mosi_ff1 <= 1'b0;
      mosi_ff2 <= 1'b0;
      mosi_ff3 <= 1'b0;
    end else begin
      ss_n_ff1 <= SS_n;
      ss_n_ff2 <= ss_n_ff1;
      ss_n_ff3 <= ss_n_ff2;
      sclk_ff1 <= SCLK;
      sclk_ff2 <= sclk_ff1;
      sclk_ff3 <= sclk_ff2;
      mosi_ff1 <= MOSI;
      mosi_ff2 <= mosi_ff1;
      mosi_ff3 <= mosi_ff2;
    end
  end

  assign ss_fall   =  ss_n_ff3 & ~ss_n_ff2;
  assign ss_rise   = ~ss_n_ff3 &  ss_n_ff2;
  assign sclk_rise = ~sclk_ff3 &  sclk_ff2;
  assign sclk_fall =  sclk_ff3 & ~sclk_ff2;

`ifdef A2D_SERF_CHK_EN
  assign cmd_ok = (rx_shft[15:14] == 2'b00) && (rx_shft[10:0] == 11'h000);
`else
  logic unused_rsvd;
  assign cmd_ok      = 1'b1;
  assign unused_rsvd = ^{rx_shft[15:14], rx_shft[10:0], MIN_HALF_SCLK[0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_vld   = 1'b0;
    prot_err  = 1'b0;
    chnnl_ld  = 1'b0;
    case (state)
      IDLE:  if (ss_fall) state_nxt = SHIFT;
      SHIFT: if (ss_rise) state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        if ((bit_cnt == 5'd16) && !extra_rise && cmd_ok) begin
          cmd_vld  = 1'b1;
          chnnl_ld = 1'b1;
        end else begin
          prot_err = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An SS_n rise wins over an SCLK edge seen in the same clk; the edge is
  // dropped. The first SCLK fall (bit_cnt == 0) is skipped so bit 15 stays
  // on MISO until the first rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft    <= '0;
      rx_shft    <= '0;
      bit_cnt    <= '0;
      extra_rise <= 1'b0;
      chnnl      <= RST_CHNL;
    end else begin
      if (chnnl_ld) chnnl <= rx_shft[13:11];
      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_shft    <= {4'h0, smpl};
            rx_shft    <= '0;
            bit_cnt    <= '0;
            extra_rise <= 1'b0;
          end
        end
        SHIFT: begin
          if (!ss_rise) begin
            if (sclk_rise) begin
              rx_shft <= {rx_shft[14:0], mosi_ff3};
              if (bit_cnt == 5'd16) extra_rise <= 1'b1;
              else                  bit_cnt    <= bit_cnt + 5'd1;
            end else if (sclk_fall && (bit_cnt != 5'd0)) begin
              tx_shft <= {tx_shft[14:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign MISO = ~ss_n_ff2 & tx_shft[15];

`ifdef A2D_SERF_CHK_EN
  logic [7:0] half_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      half_cnt <= '1;
    else if (sclk_rise || sclk_fall) half_cnt <= '0;
    else if (half_cnt != 8'hFF)      half_cnt <= half_cnt + 8'd1;
  end

  // half_cnt reads N-1 at an edge that follows the previous one by N clks.
  a_half_sclk: assert property (@(posedge clk) disable iff (!rst_n)
    ((state == SHIFT) && (sclk_rise || sclk_fall)) |->
      ({24'd0, half_cnt} >= 32'(MIN_HALF_SCLK - 1)));
`endif

endmodule

// File: tb/tb_a2d_spi_serf.sv
module tb_a2d_spi_serf;

  localparam int HALF = 16;  // SCLK = clk/32

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [2:0]  chnnl;
  logic [11:0] smpl;
  logic        cmd_vld;
  logic        prot_err;

  int n_chk = 0;
  int n_err = 0;
  int vld_cnt = 0;
  int perr_cnt = 0;
  int vld_base, perr_base;
  logic [15:0] rd_word, rd_word2;

  a2d_spi_serf #(.RST_CHNL(3'd0), .MIN_HALF_SCLK(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .chnnl    (chnnl),
    .smpl     (smpl),
    .cmd_vld  (cmd_vld),
    .prot_err (prot_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_vld)  vld_cnt++;
    if (prot_err) perr_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SS_n window: nrises SCLK pulses, MISO captured just before each of
  // the first 16 rises. If close is set, SS_n is raised and held for gap clks.
  task automatic frame(input logic [15:0] cmd, input int nrises, input bit close,
                       input int gap, output logic [15:0] word);
    word = '0;
    SS_n = 1'b0;
    clks(8);
    for (int i = 0; i < nrises; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      clks(HALF);
      if (i < 16) word[15-i] = MISO;
      SCLK = 1'b1;
      clks(HALF);
    end
    if (close) begin
      SS_n = 1'b1;
      clks(gap);
    end
  endtask

  task automatic mark;
    vld_base  = vld_cnt;
    perr_base = perr_cnt;
  endtask

  initial begin
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b1;
    MOSI  = 1'b0;
    smpl  = 12'h000;
    clks(4);
    chk("rst_miso", {15'd0, MISO}, 16'h0);
    chk("rst_chnnl", {13'd0, chnnl}, 16'h0);
    chk("rst_vld", {15'd0, cmd_vld}, 16'h0);
    chk("rst_perr", {15'd0, prot_err}, 16'h0);
    rst_n = 1'b1;
    clks(4);

    // First read after reset
    smpl = 12'hABC;
    mark();
    frame(16'h0000, 16, 1'b1, 10, rd_word);
    chk("rd0_miso", rd_word, 16'h0ABC);
    chk("rd0_vld", 16'(vld_cnt - vld_base), 16'd1);
    chk("rd0_perr", 16'(perr_cnt - perr_base), 16'd0);
    chk("rd0_chnnl", {13'd0, chnnl}, 16'h0);

    // Select channel 5, then read it
    mark();
    frame(16'h2800, 16, 1'b1, 10, rd_word);
    chk("ch5_vld", 16'(vld_cnt - vld_base), 16'd1);
    chk("ch5_chnnl", {13'd0, chnnl}, 16'h5);
    smpl = 12'h5A5;
    frame(16'h2800, 16, 1'b1, 10, rd_word);
    chk("ch5_miso", rd_word, 16'h05A5);
    chk("idle_miso", {15'd0, MISO}, 16'h0);

    // Short frame: 9 rises
    mark();
    frame(16'h1800, 9, 1'b1, 10, rd_word);
    chk("short_perr", 16'(perr_cnt - perr_base), 16'd1);
    chk("short_vld", 16'(vld_cnt - vld_base), 16'd0);
    chk("short_chnnl", {13'd0, chnnl}, 16'h5);
    smpl = 12'h123;
    mark();
    frame(16'h1800, 16, 1'b1, 10, rd_word);
    chk("post_short_miso", rd_word, 16'h0123);
    chk("post_short_vld", 16'(vld_cnt - vld_base), 16'd1);
    chk("post_short_chnnl", {13'd0, chnnl}, 16'h3);

    // Over-clocked frame: 17 rises
    mark();
    frame(16'h3800, 17, 1'b1, 10, rd_word);
    chk("over_perr", 16'(perr_cnt - perr_base), 16'd1);
    chk("over_vld", 16'(vld_cnt - vld_base), 16'd0);
    chk("over_chnnl", {13'd0, chnnl}, 16'h3);

    // Reserved bits set
    mark();
    frame(16'h2801, 16, 1'b1, 10, rd_word);
`ifdef A2D_SERF_CHK_EN
    chk("rsvd_perr", 16'(perr_cnt - perr_base), 16'd1);
    chk("rsvd_vld", 16'(vld_cnt - vld_base), 16'd0);
    chk("rsvd_chnnl", {13'd0, chnnl}, 16'h3);
`else
    chk("rsvd_perr", 16'(perr_cnt - perr_base), 16'd0);
    chk("rsvd_vld", 16'(vld_cnt - vld_base), 16'd1);
    chk("rsvd_chnnl", {13'd0, chnnl}, 16'h5);
`endif

    // Reset after 7 bits of a frame
    smpl = 12'hFFF;
    frame(16'hFFFF, 7, 1'b0, 0, rd_word);
    rst_n = 1'b0;
    clks(2);
    chk("midrst_miso", {15'd0, MISO}, 16'h0);
    chk("midrst_chnnl", {13'd0, chnnl}, 16'h0);
    SS_n = 1'b1;
    SCLK = 1'b1;
    clks(4);
    rst_n = 1'b1;
    clks(4);
    mark();
    frame(16'h3800, 16, 1'b1, 10, rd_word);
    chk("midrst_vld", 16'(vld_cnt - vld_base), 16'd1);
    chk("midrst_perr", 16'(perr_cnt - perr_base), 16'd0);
    chk("midrst_chnnl7", {13'd0, chnnl}, 16'h7);

    // Back-to-back frames, 2 clks of SS_n high between them
    mark();
    smpl = 12'h321;
    frame(16'h1000, 16, 1'b1, 2, rd_word);
    smpl = 12'h654;
    frame(16'h3000, 16, 1'b1, 10, rd_word2);
    chk("b2b_miso1", rd_word, 16'h0321);
    chk("b2b_miso2", rd_word2, 16'h0654);
    chk("b2b_vld", 16'(vld_cnt - vld_base), 16'd2);
    chk("b2b_perr", 16'(perr_cnt - perr_base), 16'd0);
    chk("b2b_chnnl", {13'd0, chnnl}, 16'h6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
